// File: rtl/ec_scalar_mul_ctrl_pkg.sv
// rtl/ec_scalar_mul_ctrl_pkg.sv - shared constants, FSM state and affine point type
package ec_scalar_mul_ctrl_pkg;

    localparam int WIDTH = 256;   // scalar and coordinate width
    localparam int IDX_W = 8;     // bit-index counter width, log2(WIDTH)

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DBL_REQ,
        S_DBL_WAIT,
        S_ADD_REQ,
        S_ADD_WAIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
    } point_t;

endpackage

// File: rtl/ec_scalar_mul_ctrl_if.sv
// rtl/ec_scalar_mul_ctrl_if.sv - start/result bus plus request/response bus to the point-add unit
//
// Host side : in_valid, k, Gx, Gy -> busy, out_valid, Rx, Ry, out_inf
// Add side  : add_in_valid, add_Px/Py/Qx/Qy -> add_Rx, add_Ry, add_out_valid
// slave     : the scalar-multiply controller
// master    : its environment (key-gen/ECDH logic together with the add unit)
interface ec_scalar_mul_ctrl_if;
    import ec_scalar_mul_ctrl_pkg::*;

    logic             in_valid;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] Gx;
    logic [WIDTH-1:0] Gy;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] Rx;
    logic [WIDTH-1:0] Ry;
    logic             out_inf;

    logic             add_in_valid;
    logic [WIDTH-1:0] add_Px;
    logic [WIDTH-1:0] add_Py;
    logic [WIDTH-1:0] add_Qx;
    logic [WIDTH-1:0] add_Qy;
    logic [WIDTH-1:0] add_Rx;
    logic [WIDTH-1:0] add_Ry;
    logic             add_out_valid;

    modport slave (
        input  in_valid, k, Gx, Gy,
        output busy, out_valid, Rx, Ry, out_inf,
        output add_in_valid, add_Px, add_Py, add_Qx, add_Qy,
        input  add_Rx, add_Ry, add_out_valid
    );

    modport master (
        output in_valid, k, Gx, Gy,
        input  busy, out_valid, Rx, Ry, out_inf,
        input  add_in_valid, add_Px, add_Py, add_Qx, add_Qy,
        output add_Rx, add_Ry, add_out_valid
    );

endinterface

// File: rtl/ec_scalar_mul_ctrl.sv
// rtl/ec_scalar_mul_ctrl.sv - left-to-right double-and-add sequencer computing R = k*G via an external point-add unit
//
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset; aborts any run in progress
//   bus   - ec_scalar_mul_ctrl_if.slave: start pulse with k/G, registered result,
//           and one-outstanding request/response link to the point-add unit
module ec_scalar_mul_ctrl
    import ec_scalar_mul_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    ec_scalar_mul_ctrl_if.slave   bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [WIDTH-1:0] r_k;
    point_t           r_g;
    point_t           r_r;
    point_t           w_r_nxt;

    logic             r_busy;
    logic             r_out_valid;
    logic             r_out_inf;
    point_t           r_res;
    logic             r_add_in_valid;
    point_t           r_add_p;
    point_t           r_add_q;

    logic             w_bit;
    logic             w_last;
    logic             w_enter_done;
    logic             w_inf_nxt;
    point_t           w_add_r;

    assign w_bit     = r_k[r_idx];
    assign w_last    = (r_idx == '0);
    assign w_add_r.x = bus.add_Rx;
    assign w_add_r.y = bus.add_Ry;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid) w_state_nxt = S_SCAN;
            end
            S_SCAN: begin
                // Leading zeros are skipped one per cycle; the first 1 seeds R = G.
                if (w_last)     w_state_nxt = S_DONE;
                else if (w_bit) w_state_nxt = S_DBL_REQ;
            end
            S_DBL_REQ: begin
                w_state_nxt = S_DBL_WAIT;
            end
            S_DBL_WAIT: begin
                if (bus.add_out_valid) begin
                    if (w_bit)       w_state_nxt = S_ADD_REQ;
                    else if (w_last) w_state_nxt = S_DONE;
                    else             w_state_nxt = S_DBL_REQ;
                end
            end
            S_ADD_REQ: begin
                w_state_nxt = S_ADD_WAIT;
            end
            S_ADD_WAIT: begin
                if (bus.add_out_valid) w_state_nxt = w_last ? S_DONE : S_DBL_REQ;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath next values; idx is decremented whenever the scan moves to a lower bit.
    always_comb begin
        w_idx_nxt = r_idx;
        w_r_nxt   = r_r;
        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_idx_nxt = IDX_W'(WIDTH - 1);
                    w_r_nxt   = '0;
                end
            end
            S_SCAN: begin
                if (w_bit)   w_r_nxt   = r_g;
                if (!w_last) w_idx_nxt = r_idx - IDX_W'(1);
            end
            S_DBL_WAIT: begin
                if (bus.add_out_valid) begin
                    w_r_nxt = w_add_r;
                    if (!w_bit && !w_last) w_idx_nxt = r_idx - IDX_W'(1);
                end
            end
            S_ADD_WAIT: begin
                if (bus.add_out_valid) begin
                    w_r_nxt = w_add_r;
                    if (!w_last) w_idx_nxt = r_idx - IDX_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Output decode: outputs are registered on the edge that enters the state they belong to,
    // so the result reflects the R value being written on that same edge.
    always_comb begin
        w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);
        // Reaching DONE straight from SCAN on a 0 bit means no 1 bit was ever found (k == 0).
        w_inf_nxt    = (r_state == S_SCAN) && !w_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx          <= '0;
            r_k            <= '0;
            r_g            <= '0;
            r_r            <= '0;
            r_busy         <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_inf      <= 1'b0;
            r_res          <= '0;
            r_add_in_valid <= 1'b0;
            r_add_p        <= '0;
            r_add_q        <= '0;
        end else begin
            r_idx <= w_idx_nxt;
            r_r   <= w_r_nxt;
            if (r_state == S_IDLE && bus.in_valid) begin
                r_k   <= bus.k;
                r_g.x <= bus.Gx;
                r_g.y <= bus.Gy;
            end

            r_busy         <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_out_valid    <= w_enter_done;
            r_add_in_valid <= (w_state_nxt == S_DBL_REQ) || (w_state_nxt == S_ADD_REQ);

            if (w_enter_done) begin
                r_out_inf <= w_inf_nxt;
                r_res     <= w_inf_nxt ? '0 : w_r_nxt;
            end

            // Operands change only on entry to a request state and stay put through the wait.
            if (w_state_nxt == S_DBL_REQ && r_state != S_DBL_REQ) begin
                r_add_p <= w_r_nxt;
                r_add_q <= w_r_nxt;
            end else if (w_state_nxt == S_ADD_REQ && r_state != S_ADD_REQ) begin
                r_add_p <= w_r_nxt;
                r_add_q <= r_g;
            end
        end
    end

    assign bus.busy         = r_busy;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_inf      = r_out_inf;
    assign bus.Rx           = r_res.x;
    assign bus.Ry           = r_res.y;
    assign bus.add_in_valid = r_add_in_valid;
    assign bus.add_Px       = r_add_p.x;
    assign bus.add_Py       = r_add_p.y;
    assign bus.add_Qx       = r_add_q.x;
    assign bus.add_Qy       = r_add_q.y;

endmodule
